bus_interconnect: RTL and testbench

//  Parametrised single-master, N-slave bus interconnect with registered slave select.
//  It decodes the master address against per-slave base/mask windows, with the lowest index winning.
//  It runs each access through a small FSM: select latch, slave access, then one-cycle response.
//  A watchdog turns a missing slave ack into an error response, and the first faulting address is captured.
//  It sits between the CPU master shell and memory/UART/VGA slaves and replaces the fixed combinational decode.

---
 rtl/bus_interconnect_if.sv | 48 ++++
 rtl/bus_interconnect.sv | 159 +++++++++++++++
 tb/tb_bus_interconnect.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_interconnect_if.sv
// Bus bundle between the CPU master shell, the interconnect and its slaves.
// Modports: ic (interconnect), master (CPU shell), slave (slave ports).
interface bus_interconnect_if #(
  parameter int NSLAVES = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);

  logic                      i_m_cs;
  logic                      i_m_we;
  logic [ADDR_W-1:0]         i_m_addr;
  logic [DATA_W-1:0]         i_m_dat;
  logic [DATA_W-1:0]         o_m_dat;
  logic                      o_m_ack;
  logic                      o_m_err;

  logic [NSLAVES-1:0]        o_s_cs;
  logic                      o_s_we;
  logic [ADDR_W-1:0]         o_s_addr;
  logic [DATA_W-1:0]         o_s_dat;
  logic [NSLAVES*DATA_W-1:0] i_s_dat;
  logic [NSLAVES-1:0]        i_s_ack;

  logic                      i_fault_clr;
  logic                      o_fault_valid;
  logic [ADDR_W-1:0]         o_fault_addr;

  modport ic (
    input  i_m_cs, i_m_we, i_m_addr, i_m_dat,
    input  i_s_dat, i_s_ack, i_fault_clr,
    output o_m_dat, o_m_ack, o_m_err,
    output o_s_cs, o_s_we, o_s_addr, o_s_dat,
    output o_fault_valid, o_fault_addr
  );

  modport master (
    output i_m_cs, i_m_we, i_m_addr, i_m_dat,
    output i_fault_clr,
    input  o_m_dat, o_m_ack, o_m_err,
    input  o_fault_valid, o_fault_addr
  );

  modport slave (
    input  o_s_cs, o_s_we, o_s_addr, o_s_dat,
    output i_s_dat, i_s_ack
  );

endinterface

// File: rtl/bus_interconnect.sv
// Single-master, N-slave interconnect: windowed decode, registered select,
// ack watchdog and first-fault capture. Ports: i_clk, i_reset, bus (ic).
module bus_interconnect #(
  parameter int NSLAVES = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter logic [NSLAVES*ADDR_W-1:0] SLV_BASE =
    {16'h0000, 16'hfa10, 16'hfa00},
  parameter logic [NSLAVES*ADDR_W-1:0] SLV_MASK =
    {16'h0000, 16'hfff0, 16'hfff0},
  parameter int TIMEOUT = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 8'hFF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  bus_interconnect_if.ic  bus
);

  localparam int SEL_W =
    (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdat_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdat_q;
  logic                fault_valid_q;
  logic [ADDR_W-1:0]   fault_addr_q;

  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_dat;
  logic [NSLAVES-1:0]  cs_vec;
  logic                wd_fire;

  // Scan from the top down so the lowest matching index is left last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if ((bus.i_m_addr & SLV_MASK[k*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[k*ADDR_W +: ADDR_W] &
           SLV_MASK[k*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  // Only the latched slave is looked at; other acks never reach the FSM.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    cs_vec  = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_ack   = bus.i_s_ack[k];
        sel_dat   = bus.i_s_dat[k*DATA_W +: DATA_W];
        cs_vec[k] = 1'b1;
      end
    end
  end

  assign wd_fire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_m_cs) begin
          state_d = hit ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        if (sel_ack) begin
          state_d = RESP;
        end else if (wd_fire) begin
          state_d = ERR;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdat_q        <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      rdat_q        <= '0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.i_m_cs) begin
            addr_q <= bus.i_m_addr;
            we_q   <= bus.i_m_we;
            wdat_q <= bus.i_m_dat;
            sel_q  <= hit_idx;
            cnt_q  <= '0;
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            rdat_q <= sel_dat;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
      // A clear landing on an error cycle loses to the new capture.
      if (state_q == ERR &&
          (!fault_valid_q || bus.i_fault_clr)) begin
        fault_valid_q <= 1'b1;
        fault_addr_q  <= addr_q;
      end else if (bus.i_fault_clr) begin
        fault_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_s_cs   = (state_q == ACCESS) ? cs_vec : '0;
  assign bus.o_s_we   = we_q;
  assign bus.o_s_addr = addr_q;
  assign bus.o_s_dat  = wdat_q;

  assign bus.o_m_ack  = (state_q == RESP) || (state_q == ERR);
  assign bus.o_m_err  = (state_q == ERR);
  assign bus.o_m_dat  = (state_q == RESP) ? rdat_q   :
                        (state_q == ERR)  ? ERR_DATA : '0;

  assign bus.o_fault_valid = fault_valid_q;
  assign bus.o_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: timeline model plus per-cycle compare,
// directed transactions and a second build with a narrowed slave 2 window.
module tb_bus_interconnect;

  localparam int TO   = 16;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   run = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_interconnect_if #(.NSLAVES(3), .ADDR_W(16), .DATA_W(8)) ba ();
  bus_interconnect_if #(.NSLAVES(3), .ADDR_W(16), .DATA_W(8)) bb ();

  bus_interconnect #(
    .NSLAVES(3), .ADDR_W(16), .DATA_W(8),
    .SLV_BASE({16'h0000, 16'hfa10, 16'hfa00}),
    .SLV_MASK({16'h0000, 16'hfff0, 16'hfff0}),
    .TIMEOUT(16), .ERR_DATA(8'hFF)
  ) dut_a (.i_clk(clk), .i_reset(rst), .bus(ba));

  bus_interconnect #(
    .NSLAVES(3), .ADDR_W(16), .DATA_W(8),
    .SLV_BASE({16'h0000, 16'hfa10, 16'hfa00}),
    .SLV_MASK({16'hf000, 16'hfff0, 16'hfff0}),
    .TIMEOUT(16), .ERR_DATA(8'hFF)
  ) dut_b (.i_clk(clk), .i_reset(rst), .bus(bb));

  // Expected outputs per cycle, and what the DUT actually showed.
  logic [2:0]  e_cs  [MAXC];
  logic        e_ack [MAXC];
  logic        e_err [MAXC];
  logic [7:0]  e_dat [MAXC];
  logic        e_fv  [MAXC];
  logic [15:0] e_fa  [MAXC];
  logic        e_sc  [MAXC];
  logic        e_swe [MAXC];
  logic [15:0] e_sa  [MAXC];
  logic [7:0]  e_sd  [MAXC];

  logic [2:0]  h_cs  [MAXC];
  logic        h_ack [MAXC];
  logic        h_err [MAXC];
  logic [7:0]  h_dat [MAXC];
  logic        h_fv  [MAXC];
  logic [15:0] h_fa  [MAXC];
  logic [15:0] h_sa  [MAXC];
  logic [7:0]  h_sd  [MAXC];

  bit          mfv;
  logic [15:0] mfa;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void fault_from(input int from, input bit v,
                                     input logic [15:0] a);
    for (int c = from; c < MAXC; c++) begin
      e_fv[c] = v;
      e_fa[c] = a;
    end
  endfunction

  // Window rule for build A: slave 0 = FA0x, slave 1 = FA1x, else slave 2.
  function automatic int dec_a(input logic [15:0] a);
    if ((a & 16'hfff0) == 16'hfa00) return 0;
    if ((a & 16'hfff0) == 16'hfa10) return 1;
    return 2;
  endfunction

  // w = slave wait cycles before ack (-1 = never); junk = other slave
  // that acks throughout; clr = fault clear pulsed on the response cycle.
  task automatic txn(input logic [15:0] a, input logic we,
                     input logic [7:0] wd, input int w,
                     input logic [7:0] rd, input int junk,
                     input bit clr, output int c0);
    int sel;
    int n;
    int r;
    bit ok;
    c0  = cyc;
    sel = dec_a(a);
    ok  = (w >= 0) && (w < TO);
    n   = ok ? w + 1 : TO;
    r   = c0 + 1 + n;
    ba.i_m_cs   = 1'b1;
    ba.i_m_we   = we;
    ba.i_m_addr = a;
    ba.i_m_dat  = wd;
    ba.i_s_dat  = 24'hc2c1c0;
    ba.i_s_dat[sel*8 +: 8] = rd;
    for (int c = c0 + 1; c <= c0 + n; c++) begin
      e_cs[c]  = 3'(1 << sel);
      e_sc[c]  = 1'b1;
      e_sa[c]  = a;
      e_sd[c]  = wd;
      e_swe[c] = we;
    end
    e_ack[r] = 1'b1;
    e_err[r] = !ok;
    e_dat[r] = ok ? rd : 8'hff;
    if (!ok) begin
      if (!mfv || clr) begin
        mfv = 1'b1;
        mfa = a;
        fault_from(r + 1, 1'b1, a);
      end
    end else if (clr) begin
      mfv = 1'b0;
      fault_from(r + 1, 1'b0, mfa);
    end
    for (int c = c0 + 1; c <= r; c++) begin
      step();
      ba.i_s_ack = '0;
      if (junk >= 0 && c < r) ba.i_s_ack[junk] = 1'b1;
      if (ok && c == c0 + 1 + w) ba.i_s_ack[sel] = 1'b1;
      if (c == r) begin
        ba.i_m_cs      = 1'b0;
        ba.i_fault_clr = clr;
      end
    end
    step();
    ba.i_fault_clr = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (run && cyc >= 1 && cyc < MAXC) begin
        h_cs[cyc]  = ba.o_s_cs;
        h_ack[cyc] = ba.o_m_ack;
        h_err[cyc] = ba.o_m_err;
        h_dat[cyc] = ba.o_m_dat;
        h_fv[cyc]  = ba.o_fault_valid;
        h_fa[cyc]  = ba.o_fault_addr;
        h_sa[cyc]  = ba.o_s_addr;
        h_sd[cyc]  = ba.o_s_dat;
        chk("cs",  ba.o_s_cs,        e_cs[cyc]);
        chk("ack", ba.o_m_ack,       e_ack[cyc]);
        chk("err", ba.o_m_err,       e_err[cyc]);
        chk("dat", ba.o_m_dat,       e_dat[cyc]);
        chk("fv",  ba.o_fault_valid, e_fv[cyc]);
        chk("fa",  ba.o_fault_addr,  e_fa[cyc]);
        if (e_sc[cyc]) begin
          chk("s_addr", ba.o_s_addr, e_sa[cyc]);
          chk("s_dat",  ba.o_s_dat,  e_sd[cyc]);
          chk("s_we",   ba.o_s_we,   e_swe[cyc]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int r0, w0, u0, b0, t0, t2, c1, t3, x0;
    for (int c = 0; c < MAXC; c++) begin
      e_cs[c] = '0;  e_ack[c] = 1'b0; e_err[c] = 1'b0;
      e_dat[c] = '0; e_fv[c] = 1'b0;  e_fa[c] = '0;
      e_sc[c] = 1'b0; e_swe[c] = 1'b0;
      e_sa[c] = '0;  e_sd[c] = '0;
    end
    for (int c = 1; c <= 3; c++) e_sc[c] = 1'b1;
    mfv = 1'b0;
    mfa = '0;
    rst = 1'b1;
    ba.i_m_cs = 1'b0; ba.i_m_we = 1'b0;
    ba.i_m_addr = '0; ba.i_m_dat = '0;
    ba.i_s_dat = '0;  ba.i_s_ack = '0;
    ba.i_fault_clr = 1'b0;
    bb.i_m_cs = 1'b0; bb.i_m_we = 1'b0;
    bb.i_m_addr = '0; bb.i_m_dat = '0;
    bb.i_s_dat = '0;  bb.i_s_ack = '0;
    bb.i_fault_clr = 1'b0;
    run = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    txn(16'h1234, 1'b0, 8'h00, 0, 8'h5a, -1, 1'b0, r0);
    txn(16'hfa11, 1'b1, 8'h77, 3, 8'ha5, -1, 1'b0, w0);
    step();
    txn(16'hfa04, 1'b0, 8'h00, 2, 8'h96, 1, 1'b0, u0);
    txn(16'hfa06, 1'b0, 8'h00, 15, 8'h3c, -1, 1'b0, b0);
    step();
    txn(16'hfa03, 1'b0, 8'h00, -1, 8'h11, -1, 1'b0, t0);
    txn(16'hfa05, 1'b1, 8'h22, -1, 8'h33, -1, 1'b0, t2);
    step();
    txn(16'h4000, 1'b0, 8'h00, 1, 8'h44, -1, 1'b1, c1);
    txn(16'hfa07, 1'b0, 8'h00, -1, 8'h00, -1, 1'b0, t3);
    step();

    // Reset pulse in the second ACCESS cycle of a read to slave 0.
    x0 = cyc;
    ba.i_m_cs = 1'b1; ba.i_m_we = 1'b0;
    ba.i_m_addr = 16'hfa08; ba.i_m_dat = 8'h00;
    for (int c = x0 + 1; c <= x0 + 2; c++) begin
      e_cs[c] = 3'b001; e_sc[c] = 1'b1;
      e_sa[c] = 16'hfa08; e_sd[c] = 8'h00; e_swe[c] = 1'b0;
    end
    e_sc[x0 + 3] = 1'b1;
    mfv = 1'b0;
    mfa = '0;
    fault_from(x0 + 3, 1'b0, 16'h0000);
    step();
    step();
    rst = 1'b1;
    ba.i_m_cs = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();

    // Build B: 0x8000 misses every window.
    bb.i_m_cs = 1'b1; bb.i_m_we = 1'b1;
    bb.i_m_addr = 16'h8000; bb.i_m_dat = 8'h55;
    @(negedge clk);
    chk("b_idle_ack", bb.o_m_ack, 1'b0);
    step();
    bb.i_m_cs = 1'b0;
    @(negedge clk);
    chk("b_miss_ack", bb.o_m_ack, 1'b1);
    chk("b_miss_err", bb.o_m_err, 1'b1);
    chk("b_miss_dat", bb.o_m_dat, 8'hff);
    chk("b_miss_cs",  bb.o_s_cs,  3'b000);
    step();
    bb.i_m_cs = 1'b1; bb.i_m_we = 1'b0;
    bb.i_m_addr = 16'h9000;
    @(negedge clk);
    chk("b_fv1",  bb.o_fault_valid, 1'b1);
    chk("b_fa1",  bb.o_fault_addr,  16'h8000);
    chk("b_ack0", bb.o_m_ack,       1'b0);
    step();
    bb.i_m_cs = 1'b0;
    bb.i_fault_clr = 1'b1;
    @(negedge clk);
    chk("b_err2", bb.o_m_err, 1'b1);
    step();
    bb.i_fault_clr = 1'b0;
    @(negedge clk);
    chk("b_fv2", bb.o_fault_valid, 1'b1);
    chk("b_fa2", bb.o_fault_addr,  16'h9000);
    bb.i_fault_clr = 1'b1;
    step();
    bb.i_fault_clr = 1'b0;
    @(negedge clk);
    chk("b_fv_clr", bb.o_fault_valid, 1'b0);

    // Hand-derived timings that pin the model.
    chk("lit_rd_cs",    h_cs[r0 + 1],  3'b100);
    chk("lit_rd_cs_off", h_cs[r0 + 2], 3'b000);
    chk("lit_rd_early", h_ack[r0 + 1], 1'b0);
    chk("lit_rd_ack",   h_ack[r0 + 2], 1'b1);
    chk("lit_rd_dat",   h_dat[r0 + 2], 8'h5a);
    chk("lit_rd_err",   h_err[r0 + 2], 1'b0);
    chk("lit_b2b",      w0,            r0 + 3);
    chk("lit_wr_cs1",   h_cs[w0 + 1],  3'b010);
    chk("lit_wr_cs4",   h_cs[w0 + 4],  3'b010);
    chk("lit_wr_addr",  h_sa[w0 + 4],  16'hfa11);
    chk("lit_wr_dat",   h_sd[w0 + 4],  8'h77);
    chk("lit_wr_early", h_ack[w0 + 4], 1'b0);
    chk("lit_wr_ack",   h_ack[w0 + 5], 1'b1);
    chk("lit_junk",     h_ack[u0 + 2], 1'b0);
    chk("lit_sel_ack",  h_ack[u0 + 4], 1'b1);
    chk("lit_edge_ack", h_ack[b0 + 17], 1'b1);
    chk("lit_edge_err", h_err[b0 + 17], 1'b0);
    chk("lit_edge_dat", h_dat[b0 + 17], 8'h3c);
    chk("lit_to_cs",    h_cs[t0 + 16],  3'b001);
    chk("lit_to_early", h_ack[t0 + 16], 1'b0);
    chk("lit_to_ack",   h_ack[t0 + 17], 1'b1);
    chk("lit_to_err",   h_err[t0 + 17], 1'b1);
    chk("lit_to_dat",   h_dat[t0 + 17], 8'hff);
    chk("lit_to_fa",    h_fa[t0 + 18],  16'hfa03);
    chk("lit_to2_err",  h_err[t2 + 17], 1'b1);
    chk("lit_to2_fa",   h_fa[t2 + 18],  16'hfa03);
    chk("lit_clr_pre",  h_fv[c1 + 3],   1'b1);
    chk("lit_clr_post", h_fv[c1 + 4],   1'b0);
    chk("lit_to3_fa",   h_fa[t3 + 18],  16'hfa07);
    chk("lit_rst_pre",  h_fv[x0 + 2],   1'b1);
    chk("lit_rst_cs",   h_cs[x0 + 3],   3'b000);
    chk("lit_rst_ack",  h_ack[x0 + 3],  1'b0);
    chk("lit_rst_fv",   h_fv[x0 + 3],   1'b0);
    chk("lit_rst_fa",   h_fa[x0 + 3],   16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
